subbytes_arbiter: RTL and testbench
===================================

SUBBYTES_ARBITER -- requirements
Module: subbytes_arbiter

Interface
REQ-001 Parameter PRIO_FIXED, default 0: 0 selects round-robin arbitration; 1 selects fixed priority with requester 0 highest.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 r0_valid  in  1  requester 0 has a 128-bit block to substitute.
REQ-005 r0_ready  out  1  requester 0 request accepted this cycle.
REQ-006 r0_mode  in  1  requester 0 S-box select: 0 forward, 1 inverse.
REQ-007 r0_data  in  128  requester 0 input state.
REQ-008 r0_rvalid  out  1  requester 0 result valid, one-cycle pulse.
REQ-009 r0_rdata  out  128  requester 0 substituted result.
REQ-010 r1_valid, r1_ready, r1_mode, r1_data, r1_rvalid, r1_rdata: same directions, widths and meanings for requester 1.
REQ-011 sb_mode  out  1  mode driven to the shared registered SubBytes unit.
REQ-012 sb_state  out  128  state driven to the shared SubBytes unit.
REQ-013 sb_state_out  in  128  result from the shared SubBytes unit.

Function
REQ-014 The block SHALL share one SubBytes unit between two requesters. The unit samples sb_state and sb_mode on edge E and presents sb_state_out after E; latency is exactly 1 cycle.
REQ-015 Grant SHALL be combinational each cycle. Only one rX_ready is high, and only when rX_valid is high. Accept = rX_valid && rX_ready.
REQ-016 Round-robin (PRIO_FIXED=0): if both requesters are valid, grant the requester not granted last. If one is valid, grant it. If neither is valid, grant none.
REQ-017 Register last_grant SHALL update only on an accept. Its reset value is 1, so requester 0 wins the first contention.
REQ-018 Fixed priority (PRIO_FIXED=1): requester 0 SHALL win whenever r0_valid is high. last_grant is ignored.
REQ-019 On accept, sb_state and sb_mode SHALL carry the granted requester's data and mode in the same cycle.
REQ-020 With no accept, sb_state SHALL be 0 and sb_mode SHALL be 0.
REQ-021 On each accept, the block SHALL register issue_valid=1 and issue_id=granted index. With no accept it SHALL register issue_valid=0.
REQ-022 In the cycle after an accept, r{issue_id}_rvalid SHALL be 1 and r{issue_id}_rdata SHALL equal sb_state_out.
REQ-023 When a requester's rvalid is 0, its rdata SHALL be 0. Both rvalid signals are never high together.
REQ-024 Throughput SHALL be one accept per cycle; back-to-back accepts from the same or alternating requesters incur no bubble.
REQ-025 Responses SHALL have no backpressure; each requester always sinks rvalid.
REQ-026 A requester SHALL hold valid, mode and data stable until accepted. The arbiter is not required to handle withdrawal.
REQ-027 Simultaneous events: a new accept and the rvalid for the previous accept SHALL coexist in one cycle, for the same or different requesters.
REQ-028 A requester with rvalid high in the same cycle as a new grant is legal.
REQ-029 Under continuous dual demand, round-robin SHALL strictly alternate grants. No requester waits more than 1 cycle.

Reset
REQ-030 While rst_n is low: r0_ready, r1_ready, r0_rvalid and r1_rvalid SHALL be 0; r0_rdata, r1_rdata and sb_state SHALL be 0; sb_mode SHALL be 0; issue_valid SHALL be 0; last_grant SHALL be 1.
REQ-031 Reset asserted with a request in flight SHALL discard it. No rvalid is produced for that request after rst_n deasserts.
REQ-032 The first grant is possible in the first cycle after rst_n deasserts.
REQ-033 The shared SubBytes unit SHALL be driven from the same clk and rst_n.

Verification
REQ-034 Single request: r0 valid, mode 0, data all 8'h00 -> r0_ready=1 that cycle; next cycle r0_rvalid=1, r0_rdata = all bytes 8'h63; r1_rvalid=0.
REQ-035 Inverse mode: r1 valid, mode 1, data all 8'h63 -> next cycle r1_rvalid=1, r1_rdata = all 8'h00.
REQ-036 Contention, PRIO_FIXED=0: both valid continuously for 4 cycles from reset -> grants r0, r1, r0, r1; rvalid pulses follow one cycle later in the same order with correct data.
REQ-037 Contention, PRIO_FIXED=1: both valid for 3 cycles -> r0 granted all 3 cycles, r1_ready=0 throughout; r1 granted in the cycle after r0_valid drops.
REQ-038 Reset mid-flight: accept on r0, then assert rst_n low in the next cycle before the edge -> all outputs 0. After release, no r0_rvalid occurs without a new request.
REQ-039 Idle: both valid low for 10 cycles -> sb_state=0, sb_mode=0, no ready, no rvalid; last_grant unchanged.

Source files
------------

// File: rtl/subbytes_arbiter.sv
// Purpose : shares one registered SubBytes unit between two requesters (round-robin or fixed priority).
// Latency : grant is combinational; the result returns on rX_rvalid exactly one cycle after the accept.
// Backpres: requesters hold valid/mode/data until ready; responses carry no backpressure.
module subbytes_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         r0_valid,
    output logic         r0_ready,
    input  logic         r0_mode,
    input  logic [127:0] r0_data,
    output logic         r0_rvalid,
    output logic [127:0] r0_rdata,

    input  logic         r1_valid,
    output logic         r1_ready,
    input  logic         r1_mode,
    input  logic [127:0] r1_data,
    output logic         r1_rvalid,
    output logic [127:0] r1_rdata,

    output logic         sb_mode,
    output logic [127:0] sb_state,
    input  logic [127:0] sb_state_out
);

    // One request as seen by the shared unit: S-box direction plus the 128-bit state.
    typedef struct packed {
        logic         mode;
        logic [127:0] data;
    } blk_t;

    blk_t req0;
    blk_t req1;
    blk_t issue_blk;

    logic gnt0;
    logic gnt1;
    logic accept;

    // last_grant: index of the most recently accepted requester (reset 1 so r0 wins first contention).
    logic last_grant;
    // issue_valid/issue_id: which requester owns the result leaving the unit this cycle.
    logic issue_valid;
    logic issue_id;

    assign req0 = '{mode: r0_mode, data: r0_data};
    assign req1 = '{mode: r1_mode, data: r1_data};

    // Combinational grant; forced off while reset is held so nothing is issued during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (PRIO_FIXED) begin
                gnt0 = r0_valid;
                gnt1 = r1_valid & ~r0_valid;
            end else if (r0_valid && r1_valid) begin
                // Both asking: the one not served last goes now.
                gnt0 = last_grant;
                gnt1 = ~last_grant;
            end else begin
                gnt0 = r0_valid;
                gnt1 = r1_valid;
            end
        end
    end

    assign r0_ready = gnt0;
    assign r1_ready = gnt1;
    assign accept   = gnt0 | gnt1;

    // Steer the granted request into the shared unit; drive zeros when nothing is accepted.
    always_comb begin
        issue_blk = '0;
        if (gnt0) begin
            issue_blk = req0;
        end else if (gnt1) begin
            issue_blk = req1;
        end
    end

    assign sb_mode  = issue_blk.mode;
    assign sb_state = issue_blk.data;

    // Track arbitration history and the ownership of the result that appears next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= 1'b1;
            issue_valid <= 1'b0;
            issue_id    <= 1'b0;
        end else begin
            issue_valid <= accept;
            if (accept) begin
                issue_id   <= gnt1;
                last_grant <= gnt1;
            end
        end
    end

    // Route the unit's output to its owner only; the other requester sees zeros.
    assign r0_rvalid = issue_valid & ~issue_id;
    assign r1_rvalid = issue_valid &  issue_id;
    assign r0_rdata  = r0_rvalid ? sb_state_out : '0;
    assign r1_rdata  = r1_rvalid ? sb_state_out : '0;

endmodule

// File: tb/tb_subbytes_arbiter.sv
// Purpose : self-checking bench for subbytes_arbiter, round-robin and fixed-priority instances side by side.
// Latency : a registered SubBytes unit model sits behind each instance, returning results one cycle later.
// Backpres: requesters hold requests until accepted; responses are always sunk.
module tb_subbytes_arbiter;

    localparam logic [127:0] ALL63 = {16{8'h63}};

    logic         clk;
    logic         rst_n;

    // index [d][r]: d = instance (0 round-robin, 1 fixed priority), r = requester
    logic         in_valid  [2][2];
    logic         in_mode   [2][2];
    logic [127:0] in_data   [2][2];
    logic         out_ready [2][2];
    logic         out_rvalid[2][2];
    logic [127:0] out_rdata [2][2];
    logic         sb_mode_o [2];
    logic [127:0] sb_state_o[2];
    logic [127:0] sb_out    [2];

    logic [7:0]   fwd_t[256];
    logic [7:0]   inv_t[256];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int           last_m  [2];
    bit           pend_v  [2];
    int           pend_id [2];
    logic [127:0] pend_dat[2];
    int           win     [2];
    int           obs_gnt [2];

    subbytes_arbiter #(.PRIO_FIXED(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(in_valid[0][0]), .r0_ready(out_ready[0][0]), .r0_mode(in_mode[0][0]),
        .r0_data(in_data[0][0]), .r0_rvalid(out_rvalid[0][0]), .r0_rdata(out_rdata[0][0]),
        .r1_valid(in_valid[0][1]), .r1_ready(out_ready[0][1]), .r1_mode(in_mode[0][1]),
        .r1_data(in_data[0][1]), .r1_rvalid(out_rvalid[0][1]), .r1_rdata(out_rdata[0][1]),
        .sb_mode(sb_mode_o[0]), .sb_state(sb_state_o[0]), .sb_state_out(sb_out[0])
    );

    subbytes_arbiter #(.PRIO_FIXED(1'b1)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(in_valid[1][0]), .r0_ready(out_ready[1][0]), .r0_mode(in_mode[1][0]),
        .r0_data(in_data[1][0]), .r0_rvalid(out_rvalid[1][0]), .r0_rdata(out_rdata[1][0]),
        .r1_valid(in_valid[1][1]), .r1_ready(out_ready[1][1]), .r1_mode(in_mode[1][1]),
        .r1_data(in_data[1][1]), .r1_rvalid(out_rvalid[1][1]), .r1_rdata(out_rdata[1][1]),
        .sb_mode(sb_mode_o[1]), .sb_state(sb_state_o[1]), .sb_state_out(sb_out[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // AES S-box from GF(2^8) inversion plus the affine map
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] t;
        logic [7:0] s;
        inv = 8'h00;
        if (b != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gf_mul(inv, b);
        end
        t = inv;
        s = inv;
        for (int k = 0; k < 4; k++) begin
            t = {t[6:0], t[7]};
            s = s ^ t;
        end
        return s ^ 8'h63;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            fwd_t[i] = sbox_calc(8'(i));
            inv_t[fwd_t[i]] = 8'(i);
        end
    end

    function automatic logic [127:0] subbytes128(input logic [127:0] d, input logic m);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = m ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
        end
        return r;
    endfunction

    // Shared registered SubBytes unit behind each instance, same clock and reset.
    always_ff @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) sb_out[d] <= '0;
            else        sb_out[d] <= subbytes128(sb_state_o[d], sb_mode_o[d]);
        end
    end

    // Who should win this cycle, from the arbitration rules.
    function automatic int model_winner(input int d);
        bit v0;
        bit v1;
        v0 = (in_valid[d][0] === 1'b1);
        v1 = (in_valid[d][1] === 1'b1);
        if (!v0 && !v1) return -1;
        if (v0 && !v1)  return 0;
        if (v1 && !v0)  return 1;
        if (d == 1)     return 0;
        return 1 - last_m[d];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            last_m[d] = 1;
            pend_v[d] = 1'b0;
            pend_id[d] = 0;
            pend_dat[d] = '0;
            win[d] = -1;
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic m, input logic [127:0] dat);
        for (int d = 0; d < 2; d++) begin
            in_valid[d][r] = v;
            in_mode[d][r]  = m;
            in_data[d][r]  = dat;
        end
    endtask

    task automatic clear_all();
        set_req(0, 1'b0, 1'b0, '0);
        set_req(1, 1'b0, 1'b0, '0);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // policy 0: accepted requester re-requests; 1: it goes idle; 2: random arrivals
    task automatic next_stim(input int policy);
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
                if (win[d] == r) begin
                    in_data[d][r] = rand128();
                    in_mode[d][r] = 1'($urandom_range(0, 1));
                    if (policy == 0)      in_valid[d][r] = 1'b1;
                    else if (policy == 1) in_valid[d][r] = 1'b0;
                    else                  in_valid[d][r] = ($urandom_range(0, 3) != 0);
                end else if (policy == 2 && in_valid[d][r] !== 1'b1) begin
                    if ($urandom_range(0, 2) == 0) begin
                        in_valid[d][r] = 1'b1;
                        in_mode[d][r]  = 1'($urandom_range(0, 1));
                        in_data[d][r]  = rand128();
                    end
                end
            end
        end
    endtask

    // One clock of checking: entered just after a rising edge with inputs applied.
    task automatic cycle_check(input string tag);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int w;
            logic [127:0] exp_st;
            logic exp_md;
            w = model_winner(d);
            exp_st = '0;
            exp_md = 1'b0;
            if (w >= 0) begin
                exp_st = in_data[d][w];
                exp_md = in_mode[d][w];
            end
            for (int r = 0; r < 2; r++) begin
                logic exp_rv;
                logic [127:0] exp_rd;
                exp_rv = pend_v[d] && (pend_id[d] == r);
                exp_rd = exp_rv ? pend_dat[d] : '0;
                n_tests++;
                if (out_ready[d][r] !== (w == r)) begin
                    n_fail++;
                    $display("FAIL %s dut%0d r%0d_ready: got %b expected %b", tag, d, r, out_ready[d][r], (w == r));
                end
                n_tests++;
                if (out_rvalid[d][r] !== exp_rv) begin
                    n_fail++;
                    $display("FAIL %s dut%0d r%0d_rvalid: got %b expected %b", tag, d, r, out_rvalid[d][r], exp_rv);
                end
                n_tests++;
                if (out_rdata[d][r] !== exp_rd) begin
                    n_fail++;
                    $display("FAIL %s dut%0d r%0d_rdata: got %h expected %h", tag, d, r, out_rdata[d][r], exp_rd);
                end
            end
            n_tests++;
            if (sb_state_o[d] !== exp_st) begin
                n_fail++;
                $display("FAIL %s dut%0d sb_state: got %h expected %h", tag, d, sb_state_o[d], exp_st);
            end
            n_tests++;
            if (sb_mode_o[d] !== exp_md) begin
                n_fail++;
                $display("FAIL %s dut%0d sb_mode: got %b expected %b", tag, d, sb_mode_o[d], exp_md);
            end
            obs_gnt[d] = (out_ready[d][0] === 1'b1) ? 0 : ((out_ready[d][1] === 1'b1) ? 1 : -1);
            pend_v[d] = (w >= 0);
            pend_id[d] = w;
            pend_dat[d] = (w >= 0) ? subbytes128(exp_st, exp_md) : '0;
            if (w >= 0) last_m[d] = w;
            win[d] = w;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
                n_tests++;
                if (out_ready[d][r] !== 1'b0 || out_rvalid[d][r] !== 1'b0 || out_rdata[d][r] !== '0) begin
                    n_fail++;
                    $display("FAIL %s dut%0d r%0d outputs: got ready=%b rvalid=%b rdata=%h expected all zero",
                             tag, d, r, out_ready[d][r], out_rvalid[d][r], out_rdata[d][r]);
                end
            end
            n_tests++;
            if (sb_state_o[d] !== '0 || sb_mode_o[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s dut%0d sb: got state=%h mode=%b expected zero", tag, d, sb_state_o[d], sb_mode_o[d]);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        clear_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_gnt(input string tag, input int d, input int exp);
        n_tests++;
        if (obs_gnt[d] != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d grant: got %0d expected %0d", tag, d, obs_gnt[d], exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        set_req(0, 1'b1, 1'b0, rand128());
        set_req(1, 1'b1, 1'b1, rand128());
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle_check("first_grant");
        check_gnt("first_grant", 0, 0);
        check_gnt("first_grant", 1, 0);
        clear_all();
        cycle_check("reset_drain");
    endtask

    task automatic test_single_fwd();
        clear_all();
        set_req(0, 1'b1, 1'b0, '0);
        cycle_check("single_fwd");
        clear_all();
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (out_rvalid[d][0] !== 1'b1 || out_rdata[d][0] !== ALL63 || out_rvalid[d][1] !== 1'b0) begin
                n_fail++;
                $display("FAIL single_fwd_const dut%0d: got rvalid0=%b rdata0=%h rvalid1=%b expected 1 %h 0",
                         d, out_rvalid[d][0], out_rdata[d][0], out_rvalid[d][1], ALL63);
            end
        end
        cycle_check("single_fwd_resp");
    endtask

    task automatic test_inverse();
        clear_all();
        set_req(1, 1'b1, 1'b1, ALL63);
        cycle_check("inverse");
        clear_all();
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (out_rvalid[d][1] !== 1'b1 || out_rdata[d][1] !== '0 || out_rvalid[d][0] !== 1'b0) begin
                n_fail++;
                $display("FAIL inverse_const dut%0d: got rvalid1=%b rdata1=%h rvalid0=%b expected 1 0 0",
                         d, out_rvalid[d][1], out_rdata[d][1], out_rvalid[d][0]);
            end
        end
        cycle_check("inverse_resp");
    endtask

    task automatic test_contention_rr();
        do_reset();
        set_req(0, 1'b1, 1'b0, rand128());
        set_req(1, 1'b1, 1'b1, rand128());
        for (int i = 0; i < 4; i++) begin
            cycle_check("contention");
            check_gnt("contention_rr", 0, i % 2);
            check_gnt("contention_fx", 1, 0);
            next_stim(0);
        end
        clear_all();
        cycle_check("contention_drain");
    endtask

    task automatic test_fixed_prio();
        do_reset();
        set_req(0, 1'b1, 1'b1, rand128());
        set_req(1, 1'b1, 1'b0, rand128());
        for (int i = 0; i < 3; i++) begin
            cycle_check("fixed");
            check_gnt("fixed_r0", 1, 0);
            next_stim(0);
        end
        in_valid[0][0] = 1'b0;
        in_valid[1][0] = 1'b0;
        cycle_check("fixed_drop");
        check_gnt("fixed_r1_after_drop", 1, 1);
        clear_all();
        cycle_check("fixed_drain");
    endtask

    task automatic test_idle();
        do_reset();
        set_req(0, 1'b1, 1'($urandom_range(0, 1)), rand128());
        cycle_check("idle_pre");
        clear_all();
        repeat (10) cycle_check("idle");
        set_req(0, 1'b1, 1'b0, rand128());
        set_req(1, 1'b1, 1'b1, rand128());
        cycle_check("idle_post");
        check_gnt("idle_last_grant_rr", 0, 1);
        check_gnt("idle_last_grant_fx", 1, 0);
        clear_all();
        cycle_check("idle_drain");
    endtask

    task automatic test_back_to_back();
        clear_all();
        set_req(0, 1'b1, 1'b0, rand128());
        for (int i = 0; i < 4; i++) begin
            cycle_check("b2b_r0");
            check_gnt("b2b_r0", 0, 0);
            next_stim(0);
        end
        in_valid[0][0] = 1'b0;
        in_valid[1][0] = 1'b0;
        set_req(1, 1'b1, 1'b1, rand128());
        for (int i = 0; i < 3; i++) begin
            cycle_check("b2b_r1");
            check_gnt("b2b_r1", 1, 1);
            next_stim(0);
        end
        clear_all();
        cycle_check("b2b_drain");
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_req(0, 1'b1, 1'b0, rand128());
        cycle_check("mid_accept");
        clear_all();
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (out_rvalid[d][0] !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_inflight dut%0d r0_rvalid: got %b expected 1", d, out_rvalid[d][0]);
            end
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero_outputs("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) cycle_check("mid_after");
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle_check("random");
            next_stim(2);
        end
        clear_all();
        cycle_check("random_drain");
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        clear_all();
        test_reset();
        test_single_fwd();
        test_inverse();
        test_contention_rr();
        test_fixed_prio();
        test_idle();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
